// File: rtl/video_stream_gen_if.sv
// rtl/video_stream_gen_if.sv - pixel fetch and video output bundle for video_stream_gen
//
// Purpose: groups the frame-source fetch handshake and the timed video output
// of video_stream_gen into one bundle.
// Signals:
//   pix_req      generator -> source  pixel fetch strobe
//   pix_data     source -> generator  pixel value, valid the cycle after pix_req
//   ycbcr_vs     generator -> sink    vertical sync
//   ycbcr_hs     generator -> sink    horizontal sync
//   ycbcr_de     generator -> sink    active-video flag
//   ycbcr_y      generator -> sink    luma pixel
//   frame_start  generator -> sink    pulse at the first counter position of a frame
//   frame_done   generator -> sink    pulse at the last counter position of a frame
// Modports: master = generator side, slave = source/sink side.

interface video_stream_gen_if;
    logic       pix_req;
    logic [7:0] pix_data;
    logic       ycbcr_vs;
    logic       ycbcr_hs;
    logic       ycbcr_de;
    logic [7:0] ycbcr_y;
    logic       frame_start;
    logic       frame_done;

    modport master (
        output pix_req,
        input  pix_data,
        output ycbcr_vs,
        output ycbcr_hs,
        output ycbcr_de,
        output ycbcr_y,
        output frame_start,
        output frame_done
    );

    modport slave (
        input  pix_req,
        output pix_data,
        input  ycbcr_vs,
        input  ycbcr_hs,
        input  ycbcr_de,
        input  ycbcr_y,
        input  frame_start,
        input  frame_done
    );
endinterface

// File: rtl/video_stream_gen.sv
// rtl/video_stream_gen.sv - raster timing generator with pixel fetch and aligned video output
//
// Purpose: runs an h/v raster counter while enabled, fetches one pixel per
// active position from a frame source and emits sync, data-enable and luma
// with all outputs aligned three clocks after the counter position.
// Ports:
//   clk     in   pixel clock
//   rst_n   in   asynchronous active-low reset
//   enable  in   run request, only honoured at a frame boundary
//   busy    out  high while the raster is running
//   vid     master side of video_stream_gen_if (pix_req/pix_data, ycbcr_*, frame_*)

module video_stream_gen #(
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    output logic                  busy,
    video_stream_gen_if.master    vid
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam int H_ACT_START = H_SYNC + H_BP;
    localparam int H_ACT_END   = H_ACT_START + H_ACTIVE;
    localparam int V_ACT_START = V_SYNC + V_BP;
    localparam int V_ACT_END   = V_ACT_START + V_ACTIVE;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state, state_next;
    logic [HW-1:0] h_cnt, h_next;
    logic [VW-1:0] v_cnt, v_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            state <= state_next;
            h_cnt <= h_next;
            v_cnt <= v_next;
        end
    end

    // enable is only looked at on the last position of a frame, so a frame
    // once started always runs to completion.
    always_comb begin
        state_next = state;
        h_next     = h_cnt;
        v_next     = v_cnt;
        case (state)
            IDLE: begin
                h_next = '0;
                v_next = '0;
                if (enable) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (h_cnt == H_LAST) begin
                    h_next = '0;
                    if (v_cnt == V_LAST) begin
                        v_next = '0;
                        if (!enable) begin
                            state_next = IDLE;
                        end
                    end else begin
                        v_next = v_cnt + VW'(1);
                    end
                end else begin
                    h_next = h_cnt + HW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Position decode of the current counters (stage 0). Sync flags are kept
    // as "asserted" internally and mapped to SYNC_POL only at the output.
    logic run;
    logic h_act, v_act, h_sync, v_sync;
    logic act0, hs0, vs0, fs0, fd0;

    assign run    = (state == RUN);
    assign h_act  = (32'(h_cnt) >= H_ACT_START) && (32'(h_cnt) < H_ACT_END);
    assign v_act  = (32'(v_cnt) >= V_ACT_START) && (32'(v_cnt) < V_ACT_END);
    assign h_sync = (32'(h_cnt) < H_SYNC);
    assign v_sync = (32'(v_cnt) < V_SYNC);

    assign act0 = run && h_act && v_act;
    assign hs0  = run && h_sync;
    assign vs0  = run && v_sync;
    assign fs0  = run && (h_cnt == '0) && (v_cnt == '0);
    assign fd0  = run && (h_cnt == H_LAST) && (v_cnt == V_LAST);

    assign busy = run;

    // Stage 1 issues the fetch, stage 2 is the cycle the source answers in,
    // stage 3 is the aligned output. Timing flags ride the same three stages.
    logic hs1, vs1, fs1, fd1;
    logic req2, hs2, vs2, fs2, fd2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vid.pix_req     <= 1'b0;
            hs1             <= 1'b0;
            vs1             <= 1'b0;
            fs1             <= 1'b0;
            fd1             <= 1'b0;
            req2            <= 1'b0;
            hs2             <= 1'b0;
            vs2             <= 1'b0;
            fs2             <= 1'b0;
            fd2             <= 1'b0;
            vid.ycbcr_de    <= 1'b0;
            vid.ycbcr_hs    <= ~SYNC_POL;
            vid.ycbcr_vs    <= ~SYNC_POL;
            vid.ycbcr_y     <= 8'd0;
            vid.frame_start <= 1'b0;
            vid.frame_done  <= 1'b0;
        end else begin
            vid.pix_req     <= act0;
            hs1             <= hs0;
            vs1             <= vs0;
            fs1             <= fs0;
            fd1             <= fd0;

            req2            <= vid.pix_req;
            hs2             <= hs1;
            vs2             <= vs1;
            fs2             <= fs1;
            fd2             <= fd1;

            vid.ycbcr_de    <= req2;
            vid.ycbcr_hs    <= hs2 ? SYNC_POL : ~SYNC_POL;
            vid.ycbcr_vs    <= vs2 ? SYNC_POL : ~SYNC_POL;
            // Zero outside active video so blanking never leaks source data.
            vid.ycbcr_y     <= req2 ? vid.pix_data : 8'd0;
            vid.frame_start <= fs2;
            vid.frame_done  <= fd2;
        end
    end

endmodule

// File: tb/tb_video_stream_gen.sv
// tb/tb_video_stream_gen.sv - self-checking bench for video_stream_gen

module tb_video_stream_gen;

    localparam int HS = 2, HB = 2, HA = 4, HF = 2;
    localparam int VS = 1, VB = 1, VA = 3, VF = 1;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FR = HT * VT;
    localparam int NPIX = HA * VA;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] pix_data = 8'd0;
    logic       busy0, busy1;

    int vectors = 0;
    int miscompares = 0;

    video_stream_gen_if vif0 ();
    video_stream_gen_if vif1 ();

    assign vif0.pix_data = pix_data;
    assign vif1.pix_data = pix_data;

    video_stream_gen #(
        .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
        .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
        .SYNC_POL(1'b0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .busy(busy0), .vid(vif0)
    );

    video_stream_gen #(
        .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
        .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
        .SYNC_POL(1'b1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .busy(busy1), .vid(vif1)
    );

    always #5 clk = ~clk;

    // Frame source: answers each fetch one cycle later with the next table
    // entry, and drives random nonzero junk when no fetch is pending.
    logic [7:0] src_vals [0:NPIX-1];
    int         src_cnt = 0;
    bit         req_seen = 1'b0;

    always @(negedge clk) req_seen = rst_n && vif0.pix_req;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            src_cnt  = 0;
            pix_data = 8'd0;
        end else if (req_seen) begin
            pix_data = src_vals[src_cnt];
            src_cnt  = (src_cnt + 1) % NPIX;
        end else begin
            pix_data = 8'($urandom_range(1, 255));
        end
    end

    // Reference model: a single frame position 0..FR-1, split into h/v with
    // division, and a three-deep delay line from position to output.
    typedef struct packed {
        logic       act;
        logic       hs;
        logic       vs;
        logic       fs;
        logic       fd;
        logic [3:0] idx;
    } stage_t;

    stage_t q0 = '0, q1 = '0, q2 = '0;
    bit     mrun = 1'b0;
    int     mpos = 0;
    stage_t m_s;
    int     m_h, m_v;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0   <= '0;
            q1   <= '0;
            q2   <= '0;
            mrun <= 1'b0;
            mpos <= 0;
        end else begin
            m_h      = mpos % HT;
            m_v      = mpos / HT;
            m_s.act  = mrun && (m_h >= HS + HB) && (m_h < HS + HB + HA)
                            && (m_v >= VS + VB) && (m_v < VS + VB + VA);
            m_s.hs   = mrun && (m_h < HS);
            m_s.vs   = mrun && (m_v < VS);
            m_s.fs   = mrun && (mpos == 0);
            m_s.fd   = mrun && (mpos == FR - 1);
            m_s.idx  = m_s.act ? 4'((m_v - VS - VB) * HA + (m_h - HS - HB)) : 4'd0;
            q0 <= m_s;
            q1 <= q0;
            q2 <= q1;
            if (!mrun) begin
                if (enable) begin
                    mrun <= 1'b1;
                    mpos <= 0;
                end
            end else if (mpos == FR - 1) begin
                mpos <= 0;
                mrun <= enable;
            end else begin
                mpos <= mpos + 1;
            end
        end
    end

    function automatic logic [14:0] exp_vec(bit pol);
        return {q0.act, q2.hs ? pol : !pol, q2.vs ? pol : !pol, q2.act,
                q2.act ? src_vals[q2.idx] : 8'd0, q2.fs, q2.fd, mrun};
    endfunction

    function automatic logic [14:0] dut_vec0();
        return {vif0.pix_req, vif0.ycbcr_hs, vif0.ycbcr_vs, vif0.ycbcr_de,
                vif0.ycbcr_y, vif0.frame_start, vif0.frame_done, busy0};
    endfunction

    function automatic logic [14:0] dut_vec1();
        return {vif1.pix_req, vif1.ycbcr_hs, vif1.ycbcr_vs, vif1.ycbcr_de,
                vif1.ycbcr_y, vif1.frame_start, vif1.frame_done, busy1};
    endfunction

    localparam logic [14:0] RST_VEC0 = 15'b0_1_1_0_00000000_0_0_0;
    localparam logic [14:0] RST_VEC1 = 15'b0_0_0_0_00000000_0_0_0;

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors += 2;
        if (dut_vec0() !== RST_VEC0) begin
            miscompares++;
            $display("FAIL reset_pol0: got %h exp %h", dut_vec0(), RST_VEC0);
        end
        if (dut_vec1() !== RST_VEC1) begin
            miscompares++;
            $display("FAIL reset_pol1: got %h exp %h", dut_vec1(), RST_VEC1);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            vectors += 2;
            if (dut_vec0() !== RST_VEC0) begin
                miscompares++;
                $display("FAIL reset_idle_pol0 cyc %0d: got %h exp %h", i, dut_vec0(), RST_VEC0);
            end
            if (dut_vec1() !== RST_VEC1) begin
                miscompares++;
                $display("FAIL reset_idle_pol1 cyc %0d: got %h exp %h", i, dut_vec1(), RST_VEC1);
            end
        end
    endtask

    task automatic test_single_frame();
        int de_cnt = 0, hs0_low = 0, hs1_high = 0, vs0_low = 0, vs1_high = 0;
        int busy_cnt = 0, run_len = 0, runs = 0, bad_runs = 0;
        for (int k = 0; k < NPIX; k++) src_vals[k] = 8'($urandom_range(1, 255));
        for (int i = 0; i < FR + 10; i++) begin
            @(posedge clk);
            #1 enable = (i == 0);
            @(negedge clk);
            vectors += 2;
            if (dut_vec0() !== exp_vec(1'b0)) begin
                miscompares++;
                $display("FAIL single_pol0 cyc %0d: got %h exp %h", i, dut_vec0(), exp_vec(1'b0));
            end
            if (dut_vec1() !== exp_vec(1'b1)) begin
                miscompares++;
                $display("FAIL single_pol1 cyc %0d: got %h exp %h", i, dut_vec1(), exp_vec(1'b1));
            end
            if (vif0.ycbcr_de === 1'b1) begin
                de_cnt++;
                run_len++;
            end else if (run_len != 0) begin
                runs++;
                if (run_len != HA) bad_runs++;
                run_len = 0;
            end
            if (vif0.ycbcr_hs === 1'b0) hs0_low++;
            if (vif1.ycbcr_hs === 1'b1) hs1_high++;
            if (vif0.ycbcr_vs === 1'b0) vs0_low++;
            if (vif1.ycbcr_vs === 1'b1) vs1_high++;
            if (busy0 === 1'b1) busy_cnt++;
        end
        vectors += 8;
        if (de_cnt !== NPIX) begin miscompares++; $display("FAIL single_de_count: got %0d exp %0d", de_cnt, NPIX); end
        if (runs !== VA || bad_runs !== 0) begin miscompares++; $display("FAIL single_de_lines: got %0d lines (%0d bad) exp %0d", runs, bad_runs, VA); end
        if (hs0_low !== HS * VT) begin miscompares++; $display("FAIL single_hs_pol0: got %0d exp %0d", hs0_low, HS * VT); end
        if (hs1_high !== HS * VT) begin miscompares++; $display("FAIL single_hs_pol1: got %0d exp %0d", hs1_high, HS * VT); end
        if (vs0_low !== VS * HT) begin miscompares++; $display("FAIL single_vs_pol0: got %0d exp %0d", vs0_low, VS * HT); end
        if (vs1_high !== VS * HT) begin miscompares++; $display("FAIL single_vs_pol1: got %0d exp %0d", vs1_high, VS * HT); end
        if (busy_cnt !== FR) begin miscompares++; $display("FAIL single_busy_cycles: got %0d exp %0d", busy_cnt, FR); end
        if (busy0 !== 1'b0) begin miscompares++; $display("FAIL single_idle_after: got %0b exp 0", busy0); end
    endtask

    task automatic test_data_alignment();
        logic [7:0] got [$];
        for (int k = 0; k < NPIX; k++) src_vals[k] = 8'(k + 1);
        for (int i = 0; i < FR + 10; i++) begin
            @(posedge clk);
            #1 enable = (i == 0);
            @(negedge clk);
            vectors += 2;
            if (dut_vec0() !== exp_vec(1'b0)) begin
                miscompares++;
                $display("FAIL align_pol0 cyc %0d: got %h exp %h", i, dut_vec0(), exp_vec(1'b0));
            end
            if (vif0.ycbcr_de === 1'b1) begin
                got.push_back(vif0.ycbcr_y);
            end else if (vif0.ycbcr_y !== 8'd0) begin
                miscompares++;
                $display("FAIL align_blank_y cyc %0d: got %h exp 00", i, vif0.ycbcr_y);
            end
        end
        vectors++;
        if (got.size() !== NPIX) begin
            miscompares++;
            $display("FAIL align_count: got %0d exp %0d", got.size(), NPIX);
        end
        for (int k = 0; k < got.size() && k < NPIX; k++) begin
            vectors++;
            if (got[k] !== 8'(k + 1)) begin
                miscompares++;
                $display("FAIL align_y[%0d]: got %0d exp %0d", k, got[k], k + 1);
            end
        end
    endtask

    task automatic test_continuous();
        int fs_at [$];
        int busy_cnt = 0;
        for (int k = 0; k < NPIX; k++) src_vals[k] = 8'($urandom_range(1, 255));
        for (int i = 0; i < 3 * FR + 20; i++) begin
            @(posedge clk);
            // Only the value at each frame end matters; in between it toggles
            // randomly and must be ignored.
            if (i == 0)                   #1 enable = 1'b1;
            else if (i > 3 * FR)          #1 enable = 1'b0;
            else if (i % FR == 0)         #1 enable = (i < 3 * FR);
            else                          #1 enable = 1'($urandom_range(0, 1));
            @(negedge clk);
            vectors += 2;
            if (dut_vec0() !== exp_vec(1'b0)) begin
                miscompares++;
                $display("FAIL cont_pol0 cyc %0d: got %h exp %h", i, dut_vec0(), exp_vec(1'b0));
            end
            if (dut_vec1() !== exp_vec(1'b1)) begin
                miscompares++;
                $display("FAIL cont_pol1 cyc %0d: got %h exp %h", i, dut_vec1(), exp_vec(1'b1));
            end
            if (vif0.frame_start === 1'b1) fs_at.push_back(i);
            if (busy0 === 1'b1) busy_cnt++;
        end
        vectors += 2;
        if (fs_at.size() !== 3) begin
            miscompares++;
            $display("FAIL cont_frame_count: got %0d exp 3", fs_at.size());
        end
        if (busy_cnt !== 3 * FR) begin
            miscompares++;
            $display("FAIL cont_busy_cycles: got %0d exp %0d", busy_cnt, 3 * FR);
        end
        for (int k = 1; k < fs_at.size(); k++) begin
            vectors++;
            if (fs_at[k] - fs_at[k-1] !== FR) begin
                miscompares++;
                $display("FAIL cont_spacing[%0d]: got %0d exp %0d", k, fs_at[k] - fs_at[k-1], FR);
            end
        end
    endtask

    task automatic test_mid_disable();
        int busy_cnt = 0, fd_cnt = 0;
        for (int k = 0; k < NPIX; k++) src_vals[k] = 8'($urandom_range(1, 255));
        for (int i = 0; i < FR + 20; i++) begin
            @(posedge clk);
            #1 enable = (i <= 25);
            @(negedge clk);
            vectors += 2;
            if (dut_vec0() !== exp_vec(1'b0)) begin
                miscompares++;
                $display("FAIL middis_pol0 cyc %0d: got %h exp %h", i, dut_vec0(), exp_vec(1'b0));
            end
            if (dut_vec1() !== exp_vec(1'b1)) begin
                miscompares++;
                $display("FAIL middis_pol1 cyc %0d: got %h exp %h", i, dut_vec1(), exp_vec(1'b1));
            end
            if (busy0 === 1'b1) busy_cnt++;
            if (vif0.frame_done === 1'b1) fd_cnt++;
        end
        vectors += 3;
        if (busy_cnt !== FR) begin miscompares++; $display("FAIL middis_busy_cycles: got %0d exp %0d", busy_cnt, FR); end
        if (fd_cnt !== 1) begin miscompares++; $display("FAIL middis_frame_done: got %0d exp 1", fd_cnt); end
        if (busy0 !== 1'b0) begin miscompares++; $display("FAIL middis_idle_after: got %0b exp 0", busy0); end
    endtask

    task automatic test_reset_mid_frame();
        int fs_first = -1, fs_cnt = 0, busy_cnt = 0;
        for (int k = 0; k < NPIX; k++) src_vals[k] = 8'($urandom_range(1, 255));
        for (int i = 0; i <= 34; i++) begin
            @(posedge clk);
            #1 enable = 1'b1;
            @(negedge clk);
            vectors++;
            if (dut_vec0() !== exp_vec(1'b0)) begin
                miscompares++;
                $display("FAIL rstmid_pre cyc %0d: got %h exp %h", i, dut_vec0(), exp_vec(1'b0));
            end
        end
        rst_n = 1'b0;
        #1;
        vectors += 2;
        if (dut_vec0() !== RST_VEC0) begin
            miscompares++;
            $display("FAIL rstmid_now_pol0: got %h exp %h", dut_vec0(), RST_VEC0);
        end
        if (dut_vec1() !== RST_VEC1) begin
            miscompares++;
            $display("FAIL rstmid_now_pol1: got %h exp %h", dut_vec1(), RST_VEC1);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < FR + 10; i++) begin
            @(posedge clk);
            #1 enable = 1'b0;
            @(negedge clk);
            vectors += 2;
            if (dut_vec0() !== exp_vec(1'b0)) begin
                miscompares++;
                $display("FAIL rstmid_post_pol0 cyc %0d: got %h exp %h", i, dut_vec0(), exp_vec(1'b0));
            end
            if (dut_vec1() !== exp_vec(1'b1)) begin
                miscompares++;
                $display("FAIL rstmid_post_pol1 cyc %0d: got %h exp %h", i, dut_vec1(), exp_vec(1'b1));
            end
            if (vif0.frame_start === 1'b1) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = i;
            end
            if (busy0 === 1'b1) busy_cnt++;
        end
        vectors += 3;
        if (fs_cnt !== 1) begin miscompares++; $display("FAIL rstmid_frames: got %0d exp 1", fs_cnt); end
        if (fs_first !== 3) begin miscompares++; $display("FAIL rstmid_restart_pos: got %0d exp 3", fs_first); end
        if (busy_cnt !== FR) begin miscompares++; $display("FAIL rstmid_busy_cycles: got %0d exp %0d", busy_cnt, FR); end
    endtask

    initial begin
        for (int k = 0; k < NPIX; k++) src_vals[k] = 8'd0;
        test_reset();
        test_single_frame();
        test_data_alignment();
        test_continuous();
        test_mid_disable();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/video_stream_gen.md
VIDEO_STREAM_GEN -- requirements
Module: video_stream_gen

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- H_SYNC, 40, hsync width (clocks)
- H_BP, 220, h back porch
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, h front porch
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, v back porch
- V_ACTIVE, 720, active lines
- V_FP, 5, v front porch
- SYNC_POL, 0, asserted sync level; the inactive level is !SYNC_POL
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1, pixel clock
- rst_n, in, 1, reset, asynchronous, active-low
- enable, in, 1, run request, level
- pix_req, out, 1, pixel fetch strobe to the frame source
- pix_data, in, 8, pixel value, valid the cycle after pix_req
- ycbcr_vs, out, 1, vertical sync
- ycbcr_hs, out, 1, horizontal sync
- ycbcr_de, out, 1, active-video flag
- ycbcr_y, out, 8, luma pixel
- frame_start, out, 1, one-cycle pulse at the first counter position of a frame
- frame_done, out, 1, one-cycle pulse at the last counter position of a frame
- busy, out, 1, high while in RUN

Function
REQ-003 The block SHALL define H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP and V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP; the h counter SHALL be clog2(H_TOTAL) bits wide and the v counter clog2(V_TOTAL) bits wide.
REQ-004 Horizontal regions SHALL be ordered by h_cnt: sync [0,H_SYNC), back porch, active [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE), front porch; vertical regions SHALL use the same order on v_cnt.
REQ-005 The state machine SHALL have two states, IDLE and RUN; reset SHALL enter IDLE with h_cnt=0 and v_cnt=0.
REQ-006 In IDLE, when enable=1 the block SHALL move to RUN on the next edge with h_cnt=0 and v_cnt=0; otherwise the counters SHALL hold at 0.
REQ-007 In RUN, h_cnt SHALL increment every clock and wrap from H_TOTAL-1 to 0; v_cnt SHALL increment on that wrap and wrap from V_TOTAL-1 to 0.
REQ-008 enable SHALL be sampled only at the frame end (h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1); if enable=0 there, the block SHALL go to IDLE, otherwise it SHALL continue into the next frame; deasserting enable mid-frame SHALL NOT truncate the frame.
REQ-009 pix_req SHALL be a registered signal, high one cycle after the counters are at an active h position with an active v line.
REQ-010 ycbcr_de SHALL equal pix_req delayed 2 clocks.
REQ-011 ycbcr_hs and ycbcr_vs SHALL be driven from the h and v sync regions and delayed by the same total so that all three are aligned; the asserted level SHALL be SYNC_POL.
REQ-012 ycbcr_y SHALL be a register loaded with pix_data when the pix_req delayed by one clock is high, and loaded with 0 otherwise.
REQ-013 The result of REQ-012 SHALL be that ycbcr_y carries pix_data exactly in the cycles where ycbcr_de=1.
REQ-014 frame_start and frame_done SHALL be aligned to the output timing, each with the same delay as ycbcr_de.
REQ-015 busy SHALL be 1 in RUN and 0 in IDLE.
REQ-016 After the last frame the block SHALL emit no partial line and no partial frame; once the 2-cycle pipeline drains, all outputs SHALL be at their inactive values.
REQ-017 pix_req SHALL be asserted exactly H_ACTIVE×V_ACTIVE times per frame.

Reset
REQ-018 When rst_n=0, at any time including mid-frame, the block SHALL immediately return to IDLE, clear the counters, and clear all pipeline registers.
REQ-019 Reset values SHALL be: ycbcr_hs=ycbcr_vs=!SYNC_POL; ycbcr_de=0; ycbcr_y=0; pix_req=0; frame_start=0; frame_done=0; busy=0.
REQ-020 After rst_n is released, the first frame SHALL start only through REQ-006.

Verification
REQ-021 The bench SHALL use H=2/2/4/2 (H_TOTAL=10) and V=1/1/3/1 (V_TOTAL=6), so one frame is 60 clocks, and SHALL cover these scenarios:
- Single frame: enable pulsed high for 1 cycle -> exactly one 60-clock frame; 12 de cycles as 3 lines of 4; hs low for 2 of every 10 clocks; vs low for the first 10 clocks; then IDLE, busy=0.
- Data alignment: source returns pix_data = sequence 1..12 one cycle after each pix_req -> ycbcr_y = 1..12 on de cycles only, and 0 elsewhere.
- Continuous run: enable held high for 3 frames -> frame_start pulses are spaced exactly 60 clocks apart; no gap between frames; busy stays 1.
- Mid-frame disable: enable dropped at clock 25 of a frame -> that frame completes all 60 clocks; frame_done pulses once; then IDLE.
- Reset mid-frame: rst_n asserted at clock 33 -> all outputs at reset values on the same clock; after release with enable=1, a full frame restarts from h=0, v=0.
- SYNC_POL=1: rerun the single-frame scenario -> sync pulses high, same timing otherwise.
